alu_datapath: RTL

Operand/result datapath driven by the ALU controller's `func` and `reg_ctrl` outputs; it is the consumer end of that control interface. It captures operands A and B from the shared `din` bus under `reg_ctrl` and evaluates the selected function. It registers the result with overflow and sign flags. Single-cycle functions complete in one cycle; mod-3 functions run through an iterative sequential divider, with busy/valid status reported to the display path.

---
 rtl/alu_datapath.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_datapath.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : alu_datapath
// Brief   : Operand/result datapath with single-cycle ALU and iterative mod-3
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module alu_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       reg_ctrl,
  input  logic [3:0]       func,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             neg,
  output logic             busy,
  output logic             valid
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [3:0]      C_F_MODS = 4'b1001;
  localparam logic [WIDTH-1:0] C_THREE = WIDTH'(3);
  localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);
  localparam logic [WIDTH:0]  C_THREE_X = (WIDTH+1)'(3);

  typedef enum logic [0:0] {CALC = 1'b0, MOD = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_m;
  logic [3:0]       r_func;
  logic [CW-1:0]    r_cnt;
  logic             r_aneg, r_restart;

  logic             w_change, w_func_mod, w_new_mod;
  logic [WIDTH:0]   w_sum, w_diff, w_sub;
  logic [WIDTH-1:0] w_res, w_mag, w_modres;
  logic             w_ov, w_neg;
  logic [CW-1:0]    w_k;

  assign w_change   = reg_ctrl[0] | reg_ctrl[1] | (func != r_func);
  assign w_func_mod = (r_func[3:1] == 3'b100);
  assign w_new_mod  = (func[3:1] == 3'b100);

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  // |A| in unsigned WIDTH bits, so the most negative value maps to 2^(WIDTH-1)
  assign w_mag    = (r_func == C_F_MODS && r_a[WIDTH-1]) ? (~r_a + C_ONE) : r_a;
  assign w_k      = r_cnt - CW'(1);
  assign w_sub    = C_THREE_X << w_k;
  assign w_modres = (r_aneg && (r_m != '0)) ? (C_THREE - r_m) : r_m;

  always_comb begin
    w_res = '0;
    w_ov  = 1'b0;
    w_neg = 1'b0;
    case (r_func)
      4'b0000: begin
        w_res = w_sum[WIDTH-1:0];
        w_ov  = w_sum[WIDTH];
      end
      4'b0001: begin
        w_res = w_diff[WIDTH-1:0];
        w_ov  = w_diff[WIDTH];
      end
      4'b0010: begin
        w_res = w_sum[WIDTH-1:0];
        w_ov  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
        w_neg = w_sum[WIDTH-1];
      end
      4'b0011: begin
        w_res = w_diff[WIDTH-1:0];
        w_ov  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
        w_neg = w_diff[WIDTH-1];
      end
      4'b0100: w_res = r_a & r_b;
      4'b0101: w_res = r_a | r_b;
      4'b0110: w_res = r_a ^ r_b;
      4'b0111: w_res = r_a;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= CALC;
      r_a       <= '0;
      r_b       <= '0;
      r_func    <= '0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_aneg    <= 1'b0;
      r_restart <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      neg       <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      if (reg_ctrl[0]) r_a <= din;
      if (reg_ctrl[1]) r_b <= din;
      r_func <= func;

      case (r_state)
        CALC: begin
          if (w_change) begin
            valid <= 1'b0;
          end else if (w_func_mod) begin
            // valid low with a mod function selected means an evaluation is owed
            if (!valid) begin
              r_m     <= w_mag;
              r_aneg  <= (r_func == C_F_MODS) && r_a[WIDTH-1];
              r_cnt   <= CW'(WIDTH-1);
              busy    <= 1'b1;
              r_state <= MOD;
            end
          end else begin
            result   <= w_res;
            overflow <= w_ov;
            neg      <= w_neg;
            valid    <= 1'b1;
          end
        end
        MOD: begin
          if (w_change) begin
            if (w_new_mod) begin
              r_restart <= 1'b1;
            end else begin
              r_restart <= 1'b0;
              busy      <= 1'b0;
              r_state   <= CALC;
            end
          end else if (r_restart) begin
            r_restart <= 1'b0;
            r_m       <= w_mag;
            r_aneg    <= (r_func == C_F_MODS) && r_a[WIDTH-1];
            r_cnt     <= CW'(WIDTH-1);
          end else if (r_cnt != '0) begin
            if ({1'b0, r_m} >= w_sub) r_m <= r_m - w_sub[WIDTH-1:0];
            r_cnt <= w_k;
          end else begin
            result   <= w_modres;
            overflow <= 1'b0;
            neg      <= 1'b0;
            valid    <= 1'b1;
            busy     <= 1'b0;
            r_state  <= CALC;
          end
        end
        default: r_state <= CALC;
      endcase
    end
  end

endmodule
`default_nettype wire
